// File: rtl/prescaler_ctrl_if.sv
// -----------------------------------------------------------------------------
// prescaler_ctrl_if -- request/grant and status bundle for prescaler_ctrl.
//
// Signals
//   req0/req1       requester update requests, held high until the matching ack
//   value0/value1   requested half-period, stable while the matching req is high
//   ack0/ack1       one-cycle grant pulse back to requester 0 / 1
//   busy            a granted value is waiting to be applied
//   active_value    half-period currently in effect
//   tick            one-cycle pulse at every half-period boundary
//   out_clk         divided clock, toggles on every tick
//   err             (only with PRESCALER_CTRL_ZERO_REJECT_EN) rejected request
//
// Modports
//   master  requester side (drives req/value, observes everything else)
//   slave   prescaler side (the prescaler_ctrl block)
// -----------------------------------------------------------------------------
interface prescaler_ctrl_if #(
    parameter int WIDTH = 28
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] value0;
    logic [WIDTH-1:0] value1;
    logic             ack0;
    logic             ack1;
    logic             busy;
    logic [WIDTH-1:0] active_value;
    logic             tick;
    logic             out_clk;
`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
    logic             err;

    modport master (
        output req0, req1, value0, value1,
        input  ack0, ack1, busy, active_value, tick, out_clk, err
    );
    modport slave (
        input  req0, req1, value0, value1,
        output ack0, ack1, busy, active_value, tick, out_clk, err
    );
`else
    modport master (
        output req0, req1, value0, value1,
        input  ack0, ack1, busy, active_value, tick, out_clk
    );
    modport slave (
        input  req0, req1, value0, value1,
        output ack0, ack1, busy, active_value, tick, out_clk
    );
`endif
endinterface

// File: rtl/prescaler_ctrl.sv
// -----------------------------------------------------------------------------
// prescaler_ctrl -- programmable clock prescaler with two arbitrated requesters.
//
// A free-running edge counter divides clk_i by the active half-period and
// produces a tick pulse plus a divided clock. Two requesters can ask for a new
// half-period; a round-robin arbiter grants one at a time, and the granted
// value is applied at the next half-period boundary (or on the very next edge
// when the prescaler is stopped) so the divided clock never sees a runt phase.
//
// Ports
//   clk_i    clock, all state changes on its rising edge
//   rst_ni   asynchronous active-low reset
//   en_i     run enable; low freezes the counter and out_clk
//   bus_if   prescaler_ctrl_if.slave (requests, grants, status, outputs)
//
// Parameters
//   WIDTH        width of half-period values and of the edge counter
//   RESET_VALUE  half-period in effect after reset
//
// Configuration
//   PRESCALER_CTRL_ZERO_REJECT_EN  when defined, requests with value < 2 are
//   acked together with err and discarded; otherwise 0 and 1 both run as a
//   divide-by-one half-period.
// -----------------------------------------------------------------------------
module prescaler_ctrl #(
    parameter int WIDTH       = 28,
    parameter int RESET_VALUE = 25000000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    prescaler_ctrl_if.slave bus_if
);
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VALUE);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;         // requester with priority on a tie
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             out_clk_q, out_clk_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;

    logic [WIDTH-1:0] eff;
    logic             at_end;
    logic             cand0, cand1;
    logic             grant0, grant1;
    logic [WIDTH-1:0] grant_value;

`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
    logic             err_q, err_d;
    logic             reject;
`endif

    // A half-period of 0 behaves like 1 so the counter always has a boundary.
    assign eff    = (active_q == '0) ? WIDTH'(1) : active_q;
    assign at_end = (cnt_q == eff - WIDTH'(1));

    // A requester is a candidate only while its ack is low; this keeps a
    // still-high req from being granted twice while the requester reacts.
    assign cand0  = bus_if.req0 && !ack0_q;
    assign cand1  = bus_if.req1 && !ack1_q;
    assign grant0 = (state_q == IDLE) && cand0 && (!cand1 || !ptr_q);
    assign grant1 = (state_q == IDLE) && cand1 && (!cand0 ||  ptr_q);
    assign grant_value = grant1 ? bus_if.value1 : bus_if.value0;

`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
    assign reject = grant_value < WIDTH'(2);
`endif

    // State register plus datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            cnt_q     <= '0;
            active_q  <= RESET_VAL;
            pending_q <= RESET_VAL;
            tick_q    <= 1'b0;
            out_clk_q <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            out_clk_q <= out_clk_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
            err_q     <= err_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
                if ((grant0 || grant1) && !reject) state_d = PENDING;
`else
                if (grant0 || grant1) state_d = PENDING;
`endif
            end
            PENDING: begin
                // Stopped prescaler applies on the next edge; running one
                // waits for the current half-period to finish.
                if (!en_i || at_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        out_clk_d = out_clk_q;
        active_d  = active_q;
        pending_d = pending_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        ptr_d     = ptr_q;
`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
        err_d     = 1'b0;
`endif

        if (en_i) begin
            tick_d    = at_end;
            out_clk_d = out_clk_q ^ at_end;
            cnt_d     = at_end ? '0 : cnt_q + WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    ack0_d = grant0;
                    ack1_d = grant1;
                    // Priority passes to the requester that just lost out.
                    ptr_d  = grant0;
`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
                    if (reject) err_d = 1'b1;
                    else        pending_d = grant_value;
`else
                    pending_d = grant_value;
`endif
                end
            end
            PENDING: begin
                if (!en_i || at_end) begin
                    active_d = pending_q;
                    cnt_d    = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus_if.busy         = (state_q == PENDING);
    assign bus_if.ack0         = ack0_q;
    assign bus_if.ack1         = ack1_q;
    assign bus_if.active_value = active_q;
    assign bus_if.tick         = tick_q;
    assign bus_if.out_clk      = out_clk_q;
`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
    assign bus_if.err          = err_q;
`endif

endmodule

// File: tb/tb_prescaler_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prescaler_ctrl -- directed self-checking bench for prescaler_ctrl.
//
// A behavioural model tracks the prescaler in terms of the documented rules
// (enabled cycles elapsed in the current half-period, a pending grant, a
// round-robin owner). Every cycle, on the falling edge, all outputs are
// compared with the model; literal hand-computed checks at key points pin
// the model itself. Builds with or without PRESCALER_CTRL_ZERO_REJECT_EN.
// -----------------------------------------------------------------------------
module tb_prescaler_ctrl;
    localparam int WIDTH = 8;
    localparam int RV    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    prescaler_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

    prescaler_ctrl #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_active, m_pending, m_elapsed, m_ptr;
    bit m_busy, m_tick, m_out, m_ack0, m_ack1, m_err;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = RV; m_pending = RV; m_elapsed = 0; m_ptr = 0;
                m_busy = 0; m_tick = 0; m_out = 0; m_ack0 = 0; m_ack1 = 0; m_err = 0;
            end else begin
                int  period;
                bit  boundary, want0, want1, pick1, rej;
                int  v;
                period   = (m_active < 1) ? 1 : m_active;
                boundary = en && (m_elapsed == period - 1);
                want0    = bus_if.req0 && !m_ack0;
                want1    = bus_if.req1 && !m_ack1;
                m_tick   = boundary;
                if (boundary) m_out = !m_out;
                if (en) m_elapsed = boundary ? 0 : m_elapsed + 1;
                m_ack0 = 0; m_ack1 = 0; m_err = 0;
                if (m_busy) begin
                    if (!en || boundary) begin
                        m_active  = m_pending;
                        m_elapsed = 0;
                        m_busy    = 0;
                    end
                end else if (want0 || want1) begin
                    pick1 = want1 && (!want0 || m_ptr == 1);
                    v     = pick1 ? int'(bus_if.value1) : int'(bus_if.value0);
                    if (pick1) m_ack1 = 1; else m_ack0 = 1;
                    m_ptr = pick1 ? 0 : 1;
`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
                    rej = (v < 2);
`else
                    rej = 0;
`endif
                    if (rej) m_err = 1;
                    else begin
                        m_pending = v;
                        m_busy    = 1;
                    end
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic step();
        @(negedge clk);
        check("tick",    32'(bus_if.tick),         32'(m_tick));
        check("out_clk", 32'(bus_if.out_clk),      32'(m_out));
        check("ack0",    32'(bus_if.ack0),         32'(m_ack0));
        check("ack1",    32'(bus_if.ack1),         32'(m_ack1));
        check("busy",    32'(bus_if.busy),         32'(m_busy));
        check("active",  32'(bus_if.active_value), 32'(m_active));
`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
        check("err",     32'(bus_if.err),          32'(m_err));
`endif
    endtask

    // Step until the chosen ack is seen (bounded); returns whether it came.
    task automatic wait_ack(input int which, input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = (which == 0) ? bus_if.ack0 : bus_if.ack1;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL ack%0d_timeout: got none expected pulse within %0d cycles", which, budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = !bus_if.busy;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL busy_timeout: got busy expected idle within %0d cycles", budget);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bit seen;
        bit oc;
        int cnt;
        bus_if.req0 = 0; bus_if.req1 = 0; bus_if.value0 = '0; bus_if.value1 = '0;

        // Reset state
        repeat (3) step();
        check("rst_active", 32'(bus_if.active_value), 32'd4);
        check("rst_busy",   32'(bus_if.busy),         32'd0);
        check("rst_outclk", 32'(bus_if.out_clk),      32'd0);

        // First tick 4 cycles after release, out_clk period 8
        rst_n = 1; en = 1;
        repeat (3) step();
        check("first_tick_early", 32'(bus_if.tick), 32'd0);
        step();
        check("first_tick",   32'(bus_if.tick),    32'd1);
        check("first_rise",   32'(bus_if.out_clk), 32'd1);
        repeat (3) step();
        step();
        check("second_tick",  32'(bus_if.tick),    32'd1);
        check("first_fall",   32'(bus_if.out_clk), 32'd0);

        // req0=2 with cnt=1; applied at the cnt=3 boundary
        step();
        bus_if.req0 = 1; bus_if.value0 = 8'd2;
        step();
        check("r32_ack0", 32'(bus_if.ack0), 32'd1);
        check("r32_busy", 32'(bus_if.busy), 32'd1);
        bus_if.req0 = 0;
        step();
        check("r32_wait",   32'(bus_if.busy), 32'd1);
        step();
        check("r32_tick",   32'(bus_if.tick),         32'd1);
        check("r32_apply",  32'(bus_if.active_value), 32'd2);
        check("r32_idle",   32'(bus_if.busy),         32'd0);
        step(); check("r32_gap",   32'(bus_if.tick), 32'd0);
        step(); check("r32_tick2", 32'(bus_if.tick), 32'd1);

        // Simultaneous requests from reset: ack0 first, then ack1, final 3
        rst_n = 0;
        bus_if.req0 = 1; bus_if.value0 = 8'd6;
        bus_if.req1 = 1; bus_if.value1 = 8'd3;
        repeat (2) step();
        rst_n = 1;
        step();
        check("r33_ack0",   32'(bus_if.ack0), 32'd1);
        check("r33_noack1", 32'(bus_if.ack1), 32'd0);
        bus_if.req0 = 0;
        wait_ack(1, 20, seen);
        check("r33_mid_active", 32'(bus_if.active_value), 32'd6);
        bus_if.req1 = 0;
        wait_idle(20);
        check("r33_final", 32'(bus_if.active_value), 32'd3);

        // Stopped prescaler: req1=10 applies on the next edge
        en = 0;
        bus_if.req1 = 1; bus_if.value1 = 8'd10;
        oc = bus_if.out_clk;
        step();
        check("r34_ack1",   32'(bus_if.ack1),         32'd1);
        check("r34_old",    32'(bus_if.active_value), 32'd3);
        bus_if.req1 = 0;
        step();
        check("r34_apply",  32'(bus_if.active_value), 32'd10);
        check("r34_idle",   32'(bus_if.busy),         32'd0);
        check("r34_outclk", 32'(bus_if.out_clk),      32'(oc));
        en = 1;
        cnt = 0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            cnt++;
            seen = bus_if.tick;
        end
        check("r34_first_tick_gap", 32'(cnt), 32'd10);

        // Reset while busy discards the pending value
        bus_if.req0 = 1; bus_if.value0 = 8'd5;
        wait_ack(0, 10, seen);
        bus_if.req0 = 0;
        check("r35_busy", 32'(bus_if.busy), 32'd1);
        step();
        rst_n = 0;
        step();
        check("r35_active", 32'(bus_if.active_value), 32'd4);
        check("r35_busy0",  32'(bus_if.busy),         32'd0);
        rst_n = 1;
        repeat (30) step();
        check("r35_never_applied", 32'(bus_if.active_value), 32'd4);

        // Value 0 request
        bus_if.req0 = 1; bus_if.value0 = 8'd0;
        step();
        check("r36_ack0", 32'(bus_if.ack0), 32'd1);
        bus_if.req0 = 0;
`ifdef PRESCALER_CTRL_ZERO_REJECT_EN
        check("r36_err",  32'(bus_if.err),  32'd1);
        check("r36_busy", 32'(bus_if.busy), 32'd0);
        repeat (6) step();
        check("r36_unchanged", 32'(bus_if.active_value), 32'd4);
`else
        check("r36_busy", 32'(bus_if.busy), 32'd1);
        wait_idle(10);
        check("r36_active0", 32'(bus_if.active_value), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("r36_tick_every", 32'(bus_if.tick), 32'd1);
        end
`endif

        // Mixed traffic, model-checked every cycle
        bus_if.req0 = 1; bus_if.value0 = 8'd3;
        bus_if.req1 = 1; bus_if.value1 = 8'd1;
        for (int i = 0; i < 40 && (bus_if.req0 || bus_if.req1); i++) begin
            step();
            if (bus_if.ack0) bus_if.req0 = 0;
            if (bus_if.ack1) bus_if.req1 = 0;
        end
        check("mix_req0_done", 32'(bus_if.req0), 32'd0);
        check("mix_req1_done", 32'(bus_if.req1), 32'd0);
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
